// File: rtl/srl_fifo_ctrl.sv
// Pointer/flag controller for an external shift-register FIFO store.
// Tracks occupancy, drives the shift enable and read address, and flags errors.
module srl_fifo_ctrl #(
    parameter int ADDR_WIDTH   = 1,
    parameter int DEPTH        = 2,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write,
    output logic                  if_full_n,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic                  srl_we,
    output logic [ADDR_WIDTH-1:0] srl_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AFULL_THRESH);

    logic          wr, rd;
    logic [CW-1:0] next_count;
    logic [CW-1:0] next_m1;

    assign wr     = if_write & if_full_n;
    assign rd     = if_read & if_empty_n;
    assign srl_we = wr;

    // Simultaneous write+read keeps occupancy: the shift pushes the oldest word out past srl_addr.
    always_comb begin
        next_count = count;
        case ({wr, rd})
            2'b10:   next_count = count + ONE;
            2'b01:   next_count = count - ONE;
            default: next_count = count;
        endcase
    end

    assign next_m1 = next_count - ONE;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            count       <= '0;
            srl_addr    <= '0;
            if_full_n   <= 1'b1;
            if_empty_n  <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            count       <= next_count;
            srl_addr    <= (next_count != '0) ? next_m1[ADDR_WIDTH-1:0] : '0;
            if_empty_n  <= (next_count != '0);
            if_full_n   <= (next_count != FULL_C);
            almost_full <= (next_count >= AF_C);
        end
    end

    // A new error in the same cycle as err_clr takes priority.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (if_write & ~if_full_n)  overflow <= 1'b1;
            else if (err_clr)           overflow <= 1'b0;
            if (if_read & ~if_empty_n)  underflow <= 1'b1;
            else if (err_clr)           underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Directed bench for srl_fifo_ctrl: one DEPTH=2 and one DEPTH=4 instance.
module tb_srl_fifo_ctrl;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic w2 = 0, r2 = 0, c2 = 0;
    logic full_n2, empty_n2, we2, af2, ov2, un2;
    logic [0:0] addr2;
    logic [1:0] cnt2;

    logic w4 = 0, r4 = 0, c4 = 0;
    logic full_n4, empty_n4, we4, af4, ov4, un4;
    logic [1:0] addr4;
    logic [2:0] cnt4;

    srl_fifo_ctrl #(.ADDR_WIDTH(1), .DEPTH(2)) u2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .if_write(w2), .if_full_n(full_n2),
        .if_read(r2), .if_empty_n(empty_n2), .srl_we(we2), .srl_addr(addr2),
        .count(cnt2), .almost_full(af2), .err_clr(c2), .overflow(ov2), .underflow(un2));

    srl_fifo_ctrl #(.ADDR_WIDTH(2), .DEPTH(4), .AFULL_THRESH(3)) u4 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .if_write(w4), .if_full_n(full_n4),
        .if_read(r4), .if_empty_n(empty_n4), .srl_we(we4), .srl_addr(addr4),
        .count(cnt4), .almost_full(af4), .err_clr(c4), .overflow(ov4), .underflow(un4));

    int checks = 0, errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;

        // reset state
        chk("d2 rst count", int'(cnt2), 0);
        chk("d2 rst empty_n", int'(empty_n2), 0);
        chk("d2 rst full_n", int'(full_n2), 1);
        chk("d2 rst addr", int'(addr2), 0);
        chk("d2 rst ovf", int'(ov2), 0);
        chk("d4 rst count", int'(cnt4), 0);
        chk("d4 rst af", int'(af4), 0);
        chk("d4 rst unf", int'(un4), 0);

        // DEPTH=2: three consecutive writes
        w2 = 1; #1;
        chk("d2 we c0", int'(we2), 1);
        tick();
        chk("d2 w1 count", int'(cnt2), 1);
        chk("d2 w1 empty_n", int'(empty_n2), 1);
        chk("d2 w1 addr", int'(addr2), 0);
        chk("d2 we c1", int'(we2), 1);
        tick();
        chk("d2 w2 count", int'(cnt2), 2);
        chk("d2 w2 full_n", int'(full_n2), 0);
        chk("d2 w2 addr", int'(addr2), 1);
        chk("d2 we c2", int'(we2), 0);
        chk("d2 ovf before", int'(ov2), 0);
        tick();
        chk("d2 ovf c3", int'(ov2), 1);
        chk("d2 count held", int'(cnt2), 2);
        w2 = 0;

        // DEPTH=4: fill, watching almost_full
        w4 = 1;
        tick(); chk("d4 c1", int'(cnt4), 1); chk("d4 af c1", int'(af4), 0);
        tick(); chk("d4 c2", int'(cnt4), 2); chk("d4 af c2", int'(af4), 0);
        tick(); chk("d4 c3", int'(cnt4), 3); chk("d4 af c3", int'(af4), 1);
        tick(); chk("d4 c4", int'(cnt4), 4); chk("d4 full_n c4", int'(full_n4), 0);
        chk("d4 addr c4", int'(addr4), 3);

        // full with write+read: write rejected, read completes
        r4 = 1; #1;
        chk("d4 full we", int'(we4), 0);
        tick();
        chk("d4 fwr count", int'(cnt4), 3);
        chk("d4 fwr full_n", int'(full_n4), 1);
        chk("d4 fwr addr", int'(addr4), 2);
        chk("d4 fwr ovf", int'(ov4), 1);
        w4 = 0;
        tick();
        chk("d4 rd count", int'(cnt4), 2);
        chk("d4 rd af", int'(af4), 0);
        chk("d4 rd addr", int'(addr4), 1);

        // write+read at count 2: occupancy unchanged, shift still happens
        w4 = 1; #1;
        chk("d4 wr2 we", int'(we4), 1);
        tick();
        chk("d4 wr2 count", int'(cnt4), 2);
        chk("d4 wr2 addr", int'(addr4), 1);
        w4 = 0;

        // drain, then read while empty
        tick(); tick();
        chk("d4 drained", int'(cnt4), 0);
        chk("d4 drained empty_n", int'(empty_n4), 0);
        chk("d4 unf before", int'(un4), 0);
        tick();
        chk("d4 unf set", int'(un4), 1);
        chk("d4 unf count", int'(cnt4), 0);
        r4 = 0; c4 = 1;
        tick();
        chk("d4 clr unf", int'(un4), 0);
        chk("d4 clr ovf", int'(ov4), 0);
        r4 = 1;
        tick();
        chk("d4 clr+rd unf", int'(un4), 1);
        r4 = 0;
        tick();
        chk("d4 clr2 unf", int'(un4), 0);
        c4 = 0;

        // empty with write+read: write accepted, read rejected
        w4 = 1; r4 = 1;
        tick();
        chk("d4 ewr count", int'(cnt4), 1);
        chk("d4 ewr empty_n", int'(empty_n4), 1);
        chk("d4 ewr unf", int'(un4), 1);
        r4 = 0;
        tick(); tick();
        chk("d4 pre-rst count", int'(cnt4), 3);
        w4 = 0;

        // asynchronous reset mid-cycle
        #2 ap_rst_n = 1'b0;
        #1;
        chk("d4 arst count", int'(cnt4), 0);
        chk("d4 arst full_n", int'(full_n4), 1);
        chk("d4 arst empty_n", int'(empty_n4), 0);
        chk("d4 arst af", int'(af4), 0);
        chk("d4 arst addr", int'(addr4), 0);
        chk("d4 arst unf", int'(un4), 0);
        chk("d2 arst count", int'(cnt2), 0);
        chk("d2 arst ovf", int'(ov2), 0);
        #1 ap_rst_n = 1'b1;
        r4 = 1;
        tick();
        chk("d4 post-rst unf", int'(un4), 1);
        chk("d4 post-rst count", int'(cnt4), 0);
        r4 = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
